// File: rtl/sd_spi_cmd_sequencer_if.sv
// Command, transmit-byte and memory-read handshakes of the SD SPI command sequencer.
// Master drives commands, TxReady and memory returns; slave is the sequencer.
interface sd_spi_cmd_sequencer_if;
  logic        CmdValid;
  logic [5:0]  Command;
  logic [31:0] CommandArgument;
  logic        TxReady;
  logic        TxValid;
  logic [7:0]  TxData;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemValid;
  logic [7:0]  MemData;
  logic [11:0] DataBlockSize;
  logic        Busy;
  logic [1:0]  CardState;

  modport master (
    output CmdValid, Command, CommandArgument, TxReady, MemValid, MemData,
    input  TxValid, TxData, MemReq, MemAddr, DataBlockSize, Busy, CardState
  );

  modport slave (
    input  CmdValid, Command, CommandArgument, TxReady, MemValid, MemData,
    output TxValid, TxData, MemReq, MemAddr, DataBlockSize, Busy, CardState
  );
endinterface

// File: rtl/sd_spi_cmd_sequencer.sv
// SD card command sequencer: init FSM, R1/R3/R7 responses, CMD17 block reads; first Tx byte one cycle after CmdValid.
// Tx and memory bytes are held until TxReady / MemValid; SDCTL_DATA_CRC_EN builds the data CRC16, else CRC bytes are 0xFF.
module sd_spi_cmd_sequencer #(
  parameter int DEFAULT_BLOCK = 512,
  parameter int MAX_BLOCK     = 2048,
  parameter int INIT_POLLS    = 2
) (
  input logic                  clock,
  input logic                  reset,
  sd_spi_cmd_sequencer_if.slave io
);
  typedef enum logic [2:0] {
    WAIT_CMD, SEND_RESP, SEND_EXT, SEND_TOKEN, FETCH, SEND_DATA, SEND_CRC
  } state_t;

  localparam logic [1:0]  CARD_POWERUP = 2'd0;
  localparam logic [1:0]  CARD_IDLE    = 2'd1;
  localparam logic [1:0]  CARD_READY   = 2'd2;
  localparam logic [11:0] DEF_BLK      = 12'(DEFAULT_BLOCK);
  localparam logic [31:0] MAX_BLK      = 32'(MAX_BLOCK);
  localparam logic [7:0]  POLLS_MAX    = 8'(INIT_POLLS);

  state_t      state, state_nxt;
  logic [1:0]  card, card_nxt;
  logic        app, app_nxt;
  logic [7:0]  polls, polls_nxt;
  logic [11:0] blk, blk_nxt;
  logic        tx_vld, tx_vld_nxt;
  logic [7:0]  tx_dat, tx_dat_nxt;
  logic        mem_req, mem_req_nxt;
  logic [31:0] mem_addr, mem_addr_nxt;
  logic [31:0] ext, ext_nxt;
  logic [1:0]  ext_left, ext_left_nxt;
  logic        has_ext, has_ext_nxt;
  logic        is_read, is_read_nxt;
  logic [11:0] cnt, cnt_nxt;
  logic        crc_second, crc_second_nxt;
  logic        illegal, perr;
  logic [7:0]  crc_hi, crc_lo;

`ifdef SDCTL_DATA_CRC_EN
  logic [15:0] crc, crc_upd;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  assign crc_upd = crc16_byte(crc, tx_dat);

  // CRC covers exactly the data bytes that complete a Tx transfer.
  always_ff @(posedge clock) begin
    if (!reset || state == WAIT_CMD) crc <= '0;
    else if (state == SEND_DATA && io.TxReady) crc <= crc_upd;
  end

  assign crc_hi = crc_upd[15:8];
  assign crc_lo = crc[7:0];
`else
  assign crc_hi = 8'hFF;
  assign crc_lo = 8'hFF;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= WAIT_CMD;
      card       <= CARD_POWERUP;
      app        <= 1'b0;
      polls      <= '0;
      blk        <= DEF_BLK;
      tx_vld     <= 1'b0;
      tx_dat     <= 8'hFF;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      ext        <= '0;
      ext_left   <= '0;
      has_ext    <= 1'b0;
      is_read    <= 1'b0;
      cnt        <= '0;
      crc_second <= 1'b0;
    end else begin
      state      <= state_nxt;
      card       <= card_nxt;
      app        <= app_nxt;
      polls      <= polls_nxt;
      blk        <= blk_nxt;
      tx_vld     <= tx_vld_nxt;
      tx_dat     <= tx_dat_nxt;
      mem_req    <= mem_req_nxt;
      mem_addr   <= mem_addr_nxt;
      ext        <= ext_nxt;
      ext_left   <= ext_left_nxt;
      has_ext    <= has_ext_nxt;
      is_read    <= is_read_nxt;
      cnt        <= cnt_nxt;
      crc_second <= crc_second_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    card_nxt       = card;
    app_nxt        = app;
    polls_nxt      = polls;
    blk_nxt        = blk;
    tx_vld_nxt     = tx_vld;
    tx_dat_nxt     = tx_dat;
    mem_req_nxt    = mem_req;
    mem_addr_nxt   = mem_addr;
    ext_nxt        = ext;
    ext_left_nxt   = ext_left;
    has_ext_nxt    = has_ext;
    is_read_nxt    = is_read;
    cnt_nxt        = cnt;
    crc_second_nxt = crc_second;
    illegal        = 1'b0;
    perr           = 1'b0;

    case (state)
      WAIT_CMD: begin
        if (io.CmdValid) begin
          app_nxt     = 1'b0;
          has_ext_nxt = 1'b0;
          is_read_nxt = 1'b0;
          case (io.Command)
            6'd0: begin
              card_nxt  = CARD_IDLE;
              polls_nxt = '0;
              blk_nxt   = DEF_BLK;
            end
            6'd8: begin
              has_ext_nxt = 1'b1;
              ext_nxt     = {16'h0000, 8'h01, io.CommandArgument[7:0]};
            end
            6'd55: app_nxt = 1'b1;
            6'd41: begin
              if (!app || card == CARD_POWERUP) illegal = 1'b1;
              else if (card == CARD_IDLE) begin
                if (polls < POLLS_MAX) polls_nxt = polls + 8'd1;
                else                   card_nxt  = CARD_READY;
              end
            end
            6'd58: begin
              has_ext_nxt = 1'b1;
              ext_nxt     = 32'h80FF_8000;
            end
            6'd16: begin
              if (io.CommandArgument != '0 && io.CommandArgument <= MAX_BLK)
                blk_nxt = io.CommandArgument[11:0];
              else
                perr = 1'b1;
            end
            6'd17: begin
              if (card != CARD_READY) illegal = 1'b1;
              else begin
                is_read_nxt  = 1'b1;
                mem_addr_nxt = io.CommandArgument;
                cnt_nxt      = '0;
              end
            end
            default: illegal = 1'b1;
          endcase
          // Idle bit reflects the card state after this command takes effect.
          tx_dat_nxt = {1'b0, perr, 3'b000, illegal, 1'b0, card_nxt != CARD_READY};
          tx_vld_nxt = 1'b1;
          state_nxt  = SEND_RESP;
        end
      end
      SEND_RESP: begin
        if (io.TxReady) begin
          if (has_ext) begin
            tx_dat_nxt   = ext[31:24];
            ext_nxt      = {ext[23:0], 8'h00};
            ext_left_nxt = 2'd3;
            state_nxt    = SEND_EXT;
          end else if (is_read) begin
            tx_dat_nxt = 8'hFE;
            state_nxt  = SEND_TOKEN;
          end else begin
            tx_vld_nxt = 1'b0;
            state_nxt  = WAIT_CMD;
          end
        end
      end
      SEND_EXT: begin
        if (io.TxReady) begin
          if (ext_left == 2'd0) begin
            tx_vld_nxt = 1'b0;
            state_nxt  = WAIT_CMD;
          end else begin
            tx_dat_nxt   = ext[31:24];
            ext_nxt      = {ext[23:0], 8'h00};
            ext_left_nxt = ext_left - 2'd1;
          end
        end
      end
      SEND_TOKEN: begin
        if (io.TxReady) begin
          tx_vld_nxt  = 1'b0;
          mem_req_nxt = 1'b1;
          state_nxt   = FETCH;
        end
      end
      FETCH: begin
        if (io.MemValid) begin
          mem_req_nxt = 1'b0;
          tx_vld_nxt  = 1'b1;
          tx_dat_nxt  = io.MemData;
          state_nxt   = SEND_DATA;
        end
      end
      SEND_DATA: begin
        if (io.TxReady) begin
          if (cnt == blk - 12'd1) begin
            tx_dat_nxt     = crc_hi;
            crc_second_nxt = 1'b0;
            state_nxt      = SEND_CRC;
          end else begin
            cnt_nxt      = cnt + 12'd1;
            mem_addr_nxt = mem_addr + 32'd1;
            mem_req_nxt  = 1'b1;
            tx_vld_nxt   = 1'b0;
            state_nxt    = FETCH;
          end
        end
      end
      SEND_CRC: begin
        if (io.TxReady) begin
          if (!crc_second) begin
            tx_dat_nxt     = crc_lo;
            crc_second_nxt = 1'b1;
          end else begin
            tx_vld_nxt = 1'b0;
            state_nxt  = WAIT_CMD;
          end
        end
      end
      default: state_nxt = WAIT_CMD;
    endcase
  end

  assign io.TxValid       = tx_vld;
  assign io.TxData        = tx_dat;
  assign io.MemReq        = mem_req;
  assign io.MemAddr       = mem_addr;
  assign io.DataBlockSize = blk;
  assign io.Busy          = (state != WAIT_CMD);
  assign io.CardState     = card;
endmodule
